// File: rtl/simon_96144_out_buffer.sv
// Output buffer for the SIMON 96/144 core: captures finished blocks into a FIFO
// and streams each one out as W-bit words, most significant first.
module simon_96144_out_buffer #(
  parameter int unsigned N     = 48,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                R,
  input  logic                doneData,
  input  logic [1:0][N-1:0]   outData,
  output logic                readData,
  output logic [W-1:0]        outWord,
  output logic                outValid,
  input  logic                outReady,
  output logic                outLast,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic                empty
);

  localparam int unsigned BW  = 2 * N;
  localparam int unsigned WPB = BW / W;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW  = (WPB > 1) ? $clog2(WPB) : 1;

  typedef enum logic [0:0] {StIdle, StAck} cap_state_e;

  cap_state_e      st_q, st_d;
  logic            read_data_q, read_data_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   mem_q [DEPTH];
  logic [BW-1:0]   head;
  logic            push, pop, xfer;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign readData = read_data_q;
  assign outValid = !empty;
  assign outLast  = outValid && (idx_q == IW'(WPB - 1));
  assign head     = mem_q[rd_ptr_q];

  // Word select over constant slices keeps the mux free of variable part-selects.
  always_comb begin
    outWord = '0;
    if (!empty) begin
      for (int i = 0; i < int'(WPB); i++) begin
        if (idx_q == IW'(i)) outWord = head[(int'(WPB) - 1 - i) * int'(W) +: W];
      end
    end
  end

  // Capture FSM: one write per doneData assertion, gated by registered full.
  always_comb begin
    st_d        = st_q;
    read_data_d = read_data_q;
    push        = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (doneData && !full) begin
          push        = 1'b1;
          read_data_d = 1'b1;
          st_d        = StAck;
        end
      end
      StAck: begin
        if (!doneData) begin
          read_data_d = 1'b0;
          st_d        = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    xfer     = outValid && outReady;
    pop      = xfer && (idx_q == IW'(WPB - 1));
    idx_d    = idx_q;
    if (xfer) idx_d = pop ? '0 : idx_q + IW'(1);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      st_q        <= StIdle;
      read_data_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
    end else begin
      st_q        <= st_d;
      read_data_q <= read_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
    end
  end

  // Storage needs no reset; count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= outData;
  end

endmodule

// File: tb/tb_simon_96144_out_buffer.sv
// Directed bench for simon_96144_out_buffer: capture handshake, FIFO order,
// back-pressure, serialiser flow control and mid-stream reset.
module tb_simon_96144_out_buffer;

  logic             clk = 1'b0;
  logic             r;
  logic             done_data;
  logic [1:0][47:0] out_data;
  logic             read_data;
  logic [15:0]      out_word;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [2:0]       count;
  logic             full;
  logic             empty;

  int n_checks = 0;
  int n_errs   = 0;

  simon_96144_out_buffer dut (
    .clk      (clk),
    .R        (r),
    .doneData (done_data),
    .outData  (out_data),
    .readData (read_data),
    .outWord  (out_word),
    .outValid (out_valid),
    .outReady (out_ready),
    .outLast  (out_last),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_of(input logic [95:0] blk, input int i);
    logic [95:0] s;
    s = blk >> ((5 - i) * 16);
    return s[15:0];
  endfunction

  // Streams words first..first+n-1 of blk with outReady held high.
  task automatic expect_words(input logic [95:0] blk, input int first, input int n);
    out_ready = 1'b1;
    for (int i = first; i < first + n; i++) begin
      check_val("word_valid", out_valid, 1'b1);
      check_val("word", out_word, word_of(blk, i));
      check_val("word_last", out_last, (i == 5));
      tick();
    end
  endtask

  task automatic pulse(input logic [95:0] blk);
    done_data = 1'b1;
    out_data  = blk;
    tick();
    check_val("pulse_ack_hi", read_data, 1'b1);
    done_data = 1'b0;
    tick();
    check_val("pulse_ack_lo", read_data, 1'b0);
  endtask

  initial begin
    logic [95:0] blk;
    int          exp_idx;

    r = 1'b1; done_data = 1'b0; out_data = '0; out_ready = 1'b0;
    tick(); tick();
    r = 1'b0;
    check_val("rst_read", read_data, 1'b0);
    check_val("rst_count", count, 3'd0);
    check_val("rst_empty", empty, 1'b1);
    check_val("rst_full", full, 1'b0);
    check_val("rst_valid", out_valid, 1'b0);
    check_val("rst_word", out_word, 16'h0);
    check_val("rst_last", out_last, 1'b0);

    // Single block, sink always ready.
    blk = 96'hECAD1C6C451E3F59C5DB1AE9;
    out_ready = 1'b1; done_data = 1'b1; out_data = blk;
    tick();
    check_val("s1_ack_hi", read_data, 1'b1);
    check_val("s1_w0", out_word, 16'hECAD);
    check_val("s1_last0", out_last, 1'b0);
    done_data = 1'b0;
    tick();
    check_val("s1_ack_lo", read_data, 1'b0);
    expect_words(blk, 1, 5);
    check_val("s1_count", count, 3'd0);
    check_val("s1_empty", empty, 1'b1);
    check_val("s1_word_idle", out_word, 16'h0);

    // Fill to full, fifth block back-pressured.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) pulse(96'(k));
    check_val("s2_full", full, 1'b1);
    check_val("s2_count", count, 3'd4);
    done_data = 1'b1; out_data = 96'h5;
    tick(); tick(); tick();
    check_val("s2_held", read_data, 1'b0);
    check_val("s2_count_held", count, 3'd4);
    expect_words(96'h1, 0, 6);
    check_val("s2_after_pop_ack", read_data, 1'b0);
    check_val("s2_after_pop_cnt", count, 3'd3);
    out_ready = 1'b0;
    tick();
    check_val("s2_cap5_ack", read_data, 1'b1);
    check_val("s2_cap5_cnt", count, 3'd4);
    done_data = 1'b0;
    tick();
    check_val("s2_cap5_lo", read_data, 1'b0);
    for (int k = 2; k <= 5; k++) expect_words(96'(k), 0, 6);
    check_val("s2_drained", count, 3'd0);

    // doneData held long: one capture only.
    blk = 96'h111122223333444455556666;
    out_ready = 1'b0; done_data = 1'b1; out_data = blk;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val("s3_ack_held", read_data, 1'b1);
    end
    check_val("s3_count", count, 3'd1);
    done_data = 1'b0;
    tick();
    check_val("s3_ack_lo", read_data, 1'b0);
    check_val("s3_count_after", count, 3'd1);
    expect_words(blk, 0, 6);

    // Toggling outReady mid-block.
    blk = 96'h0123456789ABCDEFFEDCBA98;
    out_ready = 1'b0;
    pulse(blk);
    exp_idx = 0;
    for (int c = 0; c < 20 && exp_idx < 6; c++) begin
      check_val("s4_word", out_word, word_of(blk, exp_idx));
      check_val("s4_last", out_last, (exp_idx == 5));
      out_ready = (c % 2 == 0);
      tick();
      if (out_ready) exp_idx++;
    end
    check_val("s4_done", exp_idx, 6);
    check_val("s4_empty", empty, 1'b1);

    // Capture coincident with final-word pop at count=2.
    out_ready = 1'b0;
    pulse(96'hAAAA0000AAAA0000AAAA0001);
    pulse(96'hBBBB0000BBBB0000BBBB0002);
    check_val("s5_count2", count, 3'd2);
    expect_words(96'hAAAA0000AAAA0000AAAA0001, 0, 5);
    check_val("s5_last_pre", out_last, 1'b1);
    done_data = 1'b1; out_data = 96'hCCCC0000CCCC0000CCCC0003;
    tick();
    check_val("s5_ack", read_data, 1'b1);
    check_val("s5_count_same", count, 3'd2);
    done_data = 1'b0;
    expect_words(96'hBBBB0000BBBB0000BBBB0002, 0, 6);
    expect_words(96'hCCCC0000CCCC0000CCCC0003, 0, 6);
    check_val("s5_empty", empty, 1'b1);

    // Reset while in ACK with a block half streamed.
    out_ready = 1'b0;
    pulse(96'hDDDD0000DDDD0000DDDD0004);
    expect_words(96'hDDDD0000DDDD0000DDDD0004, 0, 3);
    out_ready = 1'b0; done_data = 1'b1; out_data = 96'hEEEE0000EEEE0000EEEE0005;
    tick();
    check_val("s6_ack", read_data, 1'b1);
    r = 1'b1;
    tick();
    check_val("s6_rst_ack", read_data, 1'b0);
    check_val("s6_rst_cnt", count, 3'd0);
    check_val("s6_rst_valid", out_valid, 1'b0);
    check_val("s6_rst_word", out_word, 16'h0);
    r = 1'b0; done_data = 1'b0;
    tick();
    blk = 96'h9876543210FEDCBA13579BDF;
    pulse(blk);
    check_val("s6_new_cnt", count, 3'd1);
    expect_words(blk, 0, 6);
    check_val("s6_final_empty", empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/simon_96144_out_buffer.md
Name: simon_96144_out_buffer

Overview:
- Downstream stage of the SIMON 96/144 core: consumes each finished block on the core's doneData/readData handshake.
- Buffers up to DEPTH 96-bit results in a FIFO.
- Streams each result out as 16-bit words over a valid/ready interface, for the serial host link or a UART packer.
- Back-pressure: when the FIFO is full, readData is withheld and the core stalls with doneData high.

Parameters:
N, 48, word size of the core; a block is 2N = 96 bits
DEPTH, 4, FIFO depth in blocks; power of two, >= 2
W, 16, output word width; 2N must be divisible by W, giving WPB = 2N/W = 6 words per block

Ports:
clk  in  1  system clock, rising edge
R  in  1  synchronous reset, active-high
doneData  in  1  core result valid; stays high until readData is seen
outData  in  2N  core result as [1:0][N-1:0]; outData[1] is the upper half
readData  out  1  acknowledge to core; registered
outWord  out  W  current output word
outValid  out  1  outWord valid
outReady  in  1  sink accepts outWord
outLast  out  1  outWord is the final word of a block
count  out  clog2(DEPTH+1)  blocks held
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset: when R is high at a clk edge:
  - readData=0, FIFO emptied, count=0, full=0, empty=1.
  - Word index=0, capture FSM=IDLE.
  - outValid=0, outLast=0, outWord=0.
  - Reset mid-acknowledge drops readData the next edge. A block partly streamed is discarded.
- Capture FSM has two states, IDLE and ACK.
  - IDLE -> ACK when doneData=1 and registered full=0. On that edge: write outData into FIFO[wr_ptr], advance wr_ptr (mod DEPTH), set readData=1.
  - IDLE with doneData=1 and full=1: no write, readData stays 0. Capture happens on the first edge where full has fallen.
  - ACK: readData held at 1 and no further capture. ACK -> IDLE on the first edge with doneData=0, which sets readData=0.
  - Result: exactly one capture per doneData assertion, however long doneData stays high.
  - Latency: readData rises at the clk edge that samples doneData high (subject to full).
- Full is evaluated on registered count only. A pop in the same cycle does not enable a capture; the capture is delayed one cycle.
- Serialiser, driven from the FIFO head block H:
  - outValid = !empty.
  - outWord = H[2N-1-idx*W -: W], most significant first; forced to 0 when empty.
  - outLast = outValid && (idx == WPB-1).
- Transfer rules:
  - A transfer occurs when outValid && outReady; idx then increments.
  - The transfer with idx == WPB-1 pops the head, advances rd_ptr (mod DEPTH) and clears idx to 0.
  - outValid=0 or outReady=0: idx and FIFO unchanged, outWord stable.
- Simultaneous capture and final-word pop: count unchanged, both pointers advance.
- Pointer wrap: DEPTH-1 -> 0. count is the sole full/empty authority.
- No combinational path from outReady to readData, or from doneData to outValid.

Test Plan:
- Reset, then one doneData pulse with outData=96'hECAD1C6C451E3F59C5DB1AE9 and outReady=1:
  - readData rises on the capture edge and falls one edge after doneData drops.
  - Words out: ECAD, 1C6C, 451E, 3F59, C5DB, 1AE9, with outLast only on 1AE9. count returns to 0.
- outReady=0, five doneData pulses with blocks 96'h1..96'h5:
  - The first four are captured, giving full=1 and count=4.
  - The fifth doneData is held without readData.
  - Raising outReady: after 6 transfers the fifth is captured. Output order is 1, 2, 3, 4, 5.
- doneData held high for 20 cycles: exactly one capture, count=1, readData high throughout and low one edge after doneData falls.
- outReady toggling 1,0,1,0 mid-block: outWord holds while outReady=0, no word is skipped or repeated, outLast still lands on word 6.
- Capture and final-word pop on the same edge with count=2: count stays 2 and data order is preserved.
- Assert R during ACK with a block half streamed (idx=3): next edge gives readData=0, count=0, outValid=0. A new doneData after reset captures normally.
